// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared BTB entry type, counter encodings and fetch defaults
// Rev 1.0
// ---------------------------------------------------------------------------

`ifndef STALL_WIDTH
`define STALL_WIDTH  2
`define STALL_NONE   2'd0
`define STALL_LOAD   2'd1
`define STALL_BRANCH 2'd2
`define STALL_FLUSH  2'd3
`endif

package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  // Wide enough for the smallest legal BTB (2 entries); unused upper bits stay zero.
  localparam int BTB_TAG_W = 30;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_WNT
  };

  function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [31:0] pc, input int idx_w);
    return BTB_TAG_W'(pc >> (idx_w + 2));
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_btb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_btb : direct-mapped BTB with 2-bit counters; storage only when
//             FETCH_BTB_EN is defined, otherwise predicts not-taken forever.
// Rev 1.0
// ---------------------------------------------------------------------------

module fetch_btb
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc_i,
  output logic        bp_o,
  output logic [31:0] target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_taken_i
);

  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("fetch_btb: BTB_ENTRIES must be a power of two >= 2");
  end

`ifdef FETCH_BTB_EN

  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t           btb_q [BTB_ENTRIES];
  logic [BTB_IDX_W-1:0] lkp_idx;
  logic [BTB_IDX_W-1:0] upd_idx;
  btb_entry_t           lkp_e;
  btb_entry_t           upd_cur;
  btb_entry_t           upd_d;
  logic                 lkp_hit;
  logic                 upd_hit;
  logic                 upd_we;

  assign lkp_idx = lookup_pc_i[BTB_IDX_W+1:2];
  assign upd_idx = upd_pc_i[BTB_IDX_W+1:2];

  // Lookup reads the registered array only, so a same-cycle update is not visible.
  assign lkp_e    = btb_q[lkp_idx];
  assign lkp_hit  = lkp_e.valid && (lkp_e.tag == btb_tag(lookup_pc_i, BTB_IDX_W));
  assign bp_o     = lkp_hit && lkp_e.ctr[1];
  assign target_o = bp_o ? lkp_e.target : 32'h0;

  always_comb begin
    upd_cur = btb_q[upd_idx];
    upd_hit = upd_cur.valid && (upd_cur.tag == btb_tag(upd_pc_i, BTB_IDX_W));
    upd_d   = upd_cur;
    upd_we  = 1'b0;
    if (upd_valid_i) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (upd_taken_i) begin
          upd_d.ctr    = ctr_inc(upd_cur.ctr);
          upd_d.target = upd_target_i;
        end else begin
          upd_d.ctr    = ctr_dec(upd_cur.ctr);
        end
      end else if (upd_taken_i) begin
        // Not-taken misses never allocate; taken misses evict whatever aliases here.
        upd_we = 1'b1;
        upd_d  = '{valid:  1'b1,
                   tag:    btb_tag(upd_pc_i, BTB_IDX_W),
                   target: upd_target_i,
                   ctr:    CTR_WT};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= BTB_ENTRY_RESET;
      end
    end else if (upd_we) begin
      btb_q[upd_idx] <= upd_d;
    end
  end

`else

  logic unused_btb_inputs;

  assign bp_o              = 1'b0;
  assign target_o          = 32'h0;
  assign unused_btb_inputs = ^{clk, rst, lookup_pc_i, upd_valid_i,
                               upd_pc_i, upd_target_i, upd_taken_i};

`endif

endmodule

`default_nettype wire

// File: rtl/fetch_pc_btb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_btb : fetch PC register and next-PC selection with BTB prediction
//                (prediction present only when FETCH_BTB_EN is defined).
// Rev 1.0
// ---------------------------------------------------------------------------

module fetch_pc_btb
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = FETCH_RESET_PC,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`STALL_WIDTH-1:0] stall,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic [31:0]             upd_target,
  input  logic                    upd_taken,
  output logic [31:0]             imem_addr,
  input  logic [31:0]             imem_rdata,
  output logic [31:0]             PC_if,
  output logic [31:0]             inst_if,
  output logic                    bp_if,
  output logic [31:0]             BTB_target_if
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        bp_w;
  logic [31:0] btb_tgt_w;
  logic        stall_hold;
  logic        unused_redirect_lsb;

  fetch_btb #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc_i  (pc_q),
    .bp_o         (bp_w),
    .target_o     (btb_tgt_w),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_target_i (upd_target),
    .upd_taken_i  (upd_taken)
  );

  assign stall_hold          = (stall == `STALL_LOAD) || (stall == `STALL_BRANCH);
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Redirect outranks stall: the wrong-path word is flushed downstream at IF/ID.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall_hold) begin
      pc_d = pc_q;
    end else if (bp_w) begin
      pc_d = btb_tgt_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr     = pc_q;
  assign PC_if         = pc_q;
  assign inst_if       = imem_rdata;
  assign bp_if         = bp_w;
  assign BTB_target_if = btb_tgt_w;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_btb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_pc_btb : directed stimulus checked against a behavioural fetch/BTB model
// Rev 1.0
// ---------------------------------------------------------------------------

`ifndef STALL_WIDTH
`define STALL_WIDTH  2
`define STALL_NONE   2'd0
`define STALL_LOAD   2'd1
`define STALL_BRANCH 2'd2
`define STALL_FLUSH  2'd3
`endif

module tb_fetch_pc_btb;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          N      = 16;
`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [`STALL_WIDTH-1:0] stall;
  logic                    redirect;
  logic [31:0]             redirect_pc;
  logic                    upd_valid;
  logic [31:0]             upd_pc;
  logic [31:0]             upd_target;
  logic                    upd_taken;
  logic [31:0]             imem_addr;
  logic [31:0]             imem_rdata;
  logic [31:0]             PC_if;
  logic [31:0]             inst_if;
  logic                    bp_if;
  logic [31:0]             BTB_target_if;

  always #5 clk = ~clk;

  assign imem_rdata = {imem_addr[15:0] ^ 16'hA5C3, imem_addr[31:16]};

  fetch_pc_btb #(
    .RESET_PC    (RST_PC),
    .BTB_ENTRIES (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .PC_if         (PC_if),
    .inst_if       (inst_if),
    .bp_if         (bp_if),
    .BTB_target_if (BTB_target_if)
  );

  // Model: BTB as plain arrays keyed by word index, PC as a number.
  logic [31:0] m_pc;
  bit          m_live = 1'b0;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic bit m_predict(input logic [31:0] pc, output logic [31:0] tgt);
    int unsigned i;
    i   = (pc / 4) % N;
    tgt = m_tgt[i];
    return BTB_ON && m_valid[i] && (m_tag[i] == pc / (4 * N)) && (m_ctr[i] >= 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] tgt;
    logic [31:0] npc;
    bit          p;
    int unsigned i;
    if (rst) begin
      m_pc   = RST_PC;
      m_live = 1'b1;
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 1'b0;
        m_tag[k]   = 0;
        m_tgt[k]   = 0;
        m_ctr[k]   = 1;
      end
    end else if (m_live) begin
      p = m_predict(m_pc, tgt);
      if (redirect)                                            npc = redirect_pc & ~32'd3;
      else if (stall == `STALL_LOAD || stall == `STALL_BRANCH) npc = m_pc;
      else if (p)                                              npc = tgt;
      else                                                     npc = m_pc + 32'd4;
      if (BTB_ON && upd_valid) begin
        i = (upd_pc / 4) % N;
        if (m_valid[i] && m_tag[i] == upd_pc / (4 * N)) begin
          if (upd_taken) begin
            if (m_ctr[i] < 3) m_ctr[i]++;
            m_tgt[i] = upd_target;
          end else if (m_ctr[i] > 0) begin
            m_ctr[i]--;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = upd_pc / (4 * N);
          m_tgt[i]   = upd_target;
          m_ctr[i]   = 2;
        end
      end
      m_pc = npc;
    end
  end

  always @(negedge clk) begin
    logic [31:0] tgt;
    bit          p;
    if (m_live) begin
      p = m_predict(m_pc, tgt);
      chk("PC_if", PC_if, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("inst_if", inst_if, {m_pc[15:0] ^ 16'hA5C3, m_pc[31:16]});
      chk("bp_if", {31'b0, bp_if}, {31'b0, p});
      chk("BTB_target_if", BTB_target_if, p ? tgt : 32'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = `STALL_NONE; redirect = 1'b0; redirect_pc = 0;
    upd_valid = 1'b0; upd_pc = 0; upd_target = 0; upd_taken = 1'b0;
    tick(); tick();
    chk("reset PC", PC_if, 32'h0);
    chk("reset bp", {31'b0, bp_if}, 32'h0);
    chk("reset tgt", BTB_target_if, 32'h0);

    rst = 1'b0;
    tick(); chk("seq PC 4", PC_if, 32'h4);
    tick(); chk("seq PC 8", PC_if, 32'h8);
    stall = `STALL_LOAD;
    tick(); chk("load stall hold 1", PC_if, 32'h8);
    tick(); chk("load stall hold 2", PC_if, 32'h8);
    stall = `STALL_NONE;
    tick(); chk("after stall", PC_if, 32'hC);
    stall = `STALL_BRANCH;
    tick(); chk("branch stall hold", PC_if, 32'hC);
    stall = `STALL_FLUSH;
    tick(); chk("other stall code advances", PC_if, 32'h10);

    stall = `STALL_LOAD;
    redir(32'h103);
    stall = `STALL_NONE;
    chk("redirect beats stall", PC_if, 32'h100);

    upd(32'h10, 32'h40, 1'b1);
    tick(); upd_valid = 1'b0;
    chk("PC during train", PC_if, 32'h104);
    redir(32'h10);
    chk("predict bp", {31'b0, bp_if}, BTB_ON ? 32'h1 : 32'h0);
    chk("predict tgt", BTB_target_if, BTB_ON ? 32'h40 : 32'h0);
    upd(32'h10, 32'h999, 1'b0);
    tick(); chk("no bypass next PC", PC_if, BTB_ON ? 32'h40 : 32'h14);
    upd(32'h10, 32'h0, 1'b0);
    tick();
    upd(32'h20, 32'h500, 1'b0);
    tick(); upd_valid = 1'b0;
    redir(32'h10);
    chk("weakened bp", {31'b0, bp_if}, 32'h0);
    tick(); chk("weakened next PC", PC_if, 32'h14);
    redir(32'h20);
    chk("nt miss no alloc", {31'b0, bp_if}, 32'h0);

    upd(32'h30, 32'h200, 1'b1);
    tick(); tick();
    upd(32'h30, 32'h0, 1'b0);
    tick(); upd_valid = 1'b0;
    redir(32'h30);
    chk("saturated bp", {31'b0, bp_if}, BTB_ON ? 32'h1 : 32'h0);
    tick(); chk("saturated next PC", PC_if, BTB_ON ? 32'h200 : 32'h34);

    upd(32'h10, 32'h48, 1'b1);
    tick(); tick(); upd_valid = 1'b0;
    redir(32'h10);
    chk("retrained tgt", BTB_target_if, BTB_ON ? 32'h48 : 32'h0);
    upd(32'h10 + 4 * N, 32'h80, 1'b1);
    redir(32'h100);
    upd_valid = 1'b0;
    redir(32'h10);
    chk("alias evicted bp", {31'b0, bp_if}, 32'h0);
    redir(32'h10 + 4 * N);
    chk("alias tgt", BTB_target_if, BTB_ON ? 32'h80 : 32'h0);
    tick(); chk("alias next PC", PC_if, BTB_ON ? 32'h80 : 32'h54);

    redir(32'hFFFF_FFFE);
    chk("high redirect", PC_if, 32'hFFFF_FFFC);
    tick(); chk("PC wrap", PC_if, 32'h0);

    stall = `STALL_BRANCH;
    redir(32'h50);
    tick(); chk("stall beats prediction", PC_if, 32'h50);
    stall = `STALL_NONE;

    upd(32'h60, 32'h300, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; upd_valid = 1'b0;
    chk("mid reset PC", PC_if, 32'h0);
    redir(32'h50);
    chk("BTB cleared", {31'b0, bp_if}, 32'h0);
    redir(32'h60);
    chk("pending update dropped", {31'b0, bp_if}, 32'h0);
    tick(); chk("post reset seq", PC_if, 32'h64);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_pc_btb.md
Name: fetch_pc_btb

Overview:
Instruction-fetch stage feeding the IF/ID pipeline register.
- Holds the architectural fetch PC and addresses instruction memory.
- Predicts the next PC with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters.
- Produces PC_if, inst_if, bp_if and BTB_target_if for the IF/ID register.
- Accepts mispredict redirects and BTB training updates from the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2.
BTB_IDX_W, $clog2(BTB_ENTRIES), index width; derived, not overridden.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  STALL_WIDTH  global stall code; PC holds when equal to STALL_LOAD or STALL_BRANCH
redirect  in  1  execute-stage mispredict; load redirect_pc next cycle
redirect_pc  in  32  corrected fetch address
upd_valid  in  1  BTB training strobe for a resolved branch/jump
upd_pc  in  32  PC of the resolved branch
upd_target  in  32  resolved taken target
upd_taken  in  1  resolved direction
imem_addr  out  32  instruction memory address (= PC_if); asynchronous-read memory
imem_rdata  in  32  instruction word at imem_addr, same cycle
PC_if  out  32  current fetch PC
inst_if  out  32  = imem_rdata, combinational pass-through
bp_if  out  1  predicted taken for PC_if
BTB_target_if  out  32  predicted target; 0 when bp_if=0

Behaviour:
- PC register reset: PC_if = RESET_PC. BTB reset: all valid=0, counters=2'b01, tags/targets=0. Outputs after reset: bp_if=0, BTB_target_if=0.
- Index = PC[BTB_IDX_W+1:2]. Tag = PC[31:BTB_IDX_W+2].
- Lookup is combinational on PC_if against the registered BTB.
  - hit = valid && tag match.
  - bp_if = hit && ctr[1].
  - BTB_target_if = bp_if ? target : 0.
- Next-PC priority, highest first:
  1. rst → RESET_PC.
  2. redirect → {redirect_pc[31:2], 2'b00}.
  3. stall==STALL_LOAD or stall==STALL_BRANCH → hold PC_if.
  4. bp_if → BTB_target_if.
  5. Otherwise PC_if+4, wrapping modulo 2^32.
- Redirect overrides stall in the same cycle. The IF/ID register handles flushing of the wrong-path word.
- BTB update is applied at the clock edge when upd_valid=1, independent of stall and redirect:
  - Entry hit at upd_pc:
    - upd_taken=1 → ctr saturating increment (max 2'b11), target ← upd_target.
    - upd_taken=0 → ctr saturating decrement (min 2'b00), target unchanged.
  - Entry miss:
    - upd_taken=1 → allocate/replace: valid=1, tag, target=upd_target, ctr=2'b10.
    - upd_taken=0 → no change.
- Update and lookup to the same index in the same cycle: lookup sees pre-update contents. There is no bypass.
- Reset asserted mid-operation discards pending updates. The BTB is cleared on the same edge.
- Fetch latency: a new PC is presented one cycle after the decision. inst_if is valid in the same cycle as PC_if.

Optional Feature:
FETCH_BTB_EN.
- Defined: BTB storage and prediction as above.
- Undefined: no BTB storage is synthesised.
  - bp_if=0 and BTB_target_if=0 permanently.
  - Next PC is PC+4 unless redirected, reset or stalled.
  - upd_* inputs are ignored.

Decomposition:
- Package fetch_pkg:
  - btb_entry_t struct {valid, tag, target, ctr[1:0]}.
  - Counter constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - Default RESET_PC.
  - STALL_* codes continue to come from the shared defines.
- One sub-module, fetch_btb: storage, lookup and update logic.
  - Top level keeps the PC register and the next-PC mux.

Test Plan:
1. Reset with RESET_PC=0, no stall, run 4 cycles → PC_if sequence 0,4,8,C; bp_if=0 throughout; inst_if follows imem_rdata.
2. stall=STALL_LOAD for 2 cycles at PC=8 → PC_if holds 8 for both cycles, then 0xC.
3. Same cycle as 2's stall, redirect=1, redirect_pc=0x103 → next PC_if=0x100 (redirect beats stall; low bits cleared).
4. upd_valid, upd_pc=0x10, upd_taken=1, upd_target=0x40; later fetch 0x10 → bp_if=1, BTB_target_if=0x40, next PC_if=0x40.
5. Two not-taken updates at 0x10 (ctr 10→01→00) → fetch 0x10 gives bp_if=0, next PC 0x14; a not-taken update at unallocated 0x20 leaves its entry invalid.
6. Alias at 0x10+4·BTB_ENTRIES, taken to 0x80 → replaces the 0x10 entry; fetching 0x10 now misses, bp_if=0. With FETCH_BTB_EN undefined, repeat step 4 → bp_if stays 0.
